vscale_dmem_bridge: RTL and testbench

Downstream neighbour of the core pipeline on the data side. It consumes the pipeline's two-phase data-memory port (address phase, then a data phase one cycle later) and converts each access into a single-outstanding valid/ready request/response transaction with byte write strobes. It holds the pipeline through `dmem_wait` until the response returns. Misaligned and illegal-size accesses are rejected locally and reported on `dmem_badmem_e`; they never reach the bus.

---
 rtl/vscale_dmem_bridge_pkg.sv | 18 +
 rtl/vscale_dmem_bridge_if.sv | 27 ++
 rtl/vscale_dmem_align.sv | 32 +++
 rtl/vscale_dmem_bridge.sv | 100 ++++++++++
 tb/tb_vscale_dmem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_dmem_bridge_pkg.sv
// Shared platform constants for the data-memory bridge: memory size codes and
// the bridge FSM state encoding.
package vscale_dmem_bridge_pkg;

    localparam int MEM_TYPE_WIDTH = 3;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_SIZE_B = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_SIZE_H = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_SIZE_W = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_BAD  = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/vscale_dmem_bridge_if.sv
// Single-outstanding request/response bus between the data bridge and memory.
// Handshake: a request transfers on a cycle with req_valid && req_ready; once
// raised, req_valid and all req_* fields hold until that cycle. A response
// transfers on any cycle with resp_valid (no back-pressure on responses).
interface vscale_dmem_bridge_if #(
    parameter int XPR_LEN = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_wr;
    logic [XPR_LEN-1:0] req_addr;
    logic [XPR_LEN-1:0] req_wdata;
    logic [3:0]         req_wstrb;
    logic               resp_valid;
    logic [XPR_LEN-1:0] resp_rdata;
    logic               resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/vscale_dmem_align.sv
// Byte-lane strobe and alignment check for a single memory access; purely
// combinational so the fetch-side bridge can reuse it.
module vscale_dmem_align
    import vscale_dmem_bridge_pkg::*;
(
    input  logic [1:0]                addr,
    input  logic [MEM_TYPE_WIDTH-1:0] size,
    input  logic                      wen,
    output logic [3:0]                wstrb,
    output logic                      illegal
);

    always_comb begin
        wstrb   = 4'b0000;
        illegal = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                if (wen) wstrb = 4'b0001 << addr;
            end
            MEM_SIZE_H: begin
                illegal = addr[0];
                if (wen) wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            MEM_SIZE_W: begin
                illegal = |addr;
                if (wen) wstrb = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// Converts the pipeline's two-phase data-memory port into single-outstanding
// valid/ready bus transactions, stalling the pipeline until the response.
module vscale_dmem_bridge
    import vscale_dmem_bridge_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [XPR_LEN-1:0]        dmem_addr,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic [XPR_LEN-1:0]        dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e,
    vscale_dmem_bridge_if.master      bus,
    output dmem_state_t               dbg_state
);

    dmem_state_t          state_q, state_d;
    logic                 wen_q;
    logic [XPR_LEN-1:2]   addr_q;
    logic [3:0]           wstrb_q;
    logic [3:0]           align_wstrb;
    logic                 align_illegal;
    logic                 completing;
    logic                 capture;

    // Strobes are derived at capture time and registered, which is identical
    // to decoding them from the registered addr/size.
    vscale_dmem_align u_align (
        .addr    (dmem_addr[1:0]),
        .size    (dmem_size),
        .wen     (dmem_wen),
        .wstrb   (align_wstrb),
        .illegal (align_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (capture) begin
                wen_q   <= dmem_wen;
                addr_q  <= dmem_addr[XPR_LEN-1:2];
                wstrb_q <= align_wstrb;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dmem_wait     = 1'b0;
        dmem_rdata    = '0;
        dmem_badmem_e = 1'b0;
        completing    = 1'b0;
        capture       = 1'b0;
        case (state_q)
            ST_IDLE: completing = 1'b1;
            ST_REQ: begin
                dmem_wait = 1'b1;
                if (bus.req_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                dmem_wait = !bus.resp_valid;
                if (bus.resp_valid) begin
                    completing    = 1'b1;
                    dmem_rdata    = bus.resp_rdata;
                    dmem_badmem_e = bus.resp_err;
                    state_d       = ST_IDLE;
                end
            end
            ST_BAD: begin
                completing    = 1'b1;
                dmem_badmem_e = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new address phase overlaps the completing data phase: no bubble.
        if (completing && dmem_en) begin
            capture = 1'b1;
            state_d = align_illegal ? ST_BAD : ST_REQ;
        end
    end

    assign bus.req_valid = (state_q == ST_REQ);
    assign bus.req_wr    = wen_q;
    assign bus.req_addr  = {addr_q, 2'b00};
    assign bus.req_wdata = dmem_wdata_delayed;
    assign bus.req_wstrb = wstrb_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Self-checking bench for vscale_dmem_bridge: directed cases plus randomized
// accesses, with a scoreboard of expected completions.
module tb_vscale_dmem_bridge;
    import vscale_dmem_bridge_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;
    dmem_state_t dbg_state;

    vscale_dmem_bridge_if bus ();

    vscale_dmem_bridge dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_rdata         (dmem_rdata),
        .dmem_wait          (dmem_wait),
        .dmem_badmem_e      (dmem_badmem_e),
        .bus                (bus.master),
        .dbg_state          (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    logic        nxt_en;
    logic        nxt_wen;
    logic [2:0]  nxt_size;
    logic [31:0] nxt_addr;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model
    function automatic logic model_illegal(input logic [2:0] size, input logic [31:0] addr);
        case (size)
            3'd0:    return 1'b0;
            3'd1:    return addr[0];
            3'd2:    return addr[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic wen, input logic [2:0] size,
                                              input logic [31:0] addr);
        int lo, n;
        logic [3:0] s;
        s = 4'b0000;
        if (!wen) return s;
        lo = (size == 3'd0) ? int'(addr[1:0]) : (size == 3'd1) ? (addr[1] ? 2 : 0) : 0;
        n = 1 << size;
        for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i < lo + n);
        return s;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dmem_en        = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
    endtask

    task automatic addr_phase(input logic wen, input logic [2:0] size, input logic [31:0] addr);
        dmem_en   = 1'b1;
        dmem_wen  = wen;
        dmem_size = size;
        dmem_addr = addr;
    endtask

    task automatic apply_next();
        if (nxt_en) addr_phase(nxt_wen, nxt_size, nxt_addr);
    endtask

    // Drives the data phase beginning at the next clock; returns in the
    // completion cycle (with any chained address phase already applied).
    task automatic data_phase(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int rd_dly, input int rsp_dly,
                              input logic [31:0] rdata, input logic err, input logic stray);
        logic        bad;
        logic [32:0] exp;
        bad = model_illegal(size, addr);
        exp_q.push_back(bad ? {1'b1, 32'h0} : {err, rdata});
        tick();
        clear_inputs();
        dmem_wdata_delayed = wdata;
        if (bad) begin
            apply_next();
            nxt_en = 1'b0;
            @(negedge clk);
            check_eq("bad_req_valid", bus.req_valid, 0);
            check_eq("bad_wait", dmem_wait, 0);
            check_eq("sb_nonempty", exp_q.size() > 0, 1);
            exp = exp_q.pop_front();
            check_eq("bad_badmem", dmem_badmem_e, exp[32]);
            return;
        end
        for (int k = 0; k <= rd_dly; k++) begin
            if (k > 0) tick();
            bus.req_ready  = (k == rd_dly);
            bus.resp_valid = stray && (k == rd_dly);
            bus.resp_rdata = 32'hC0DE_0000 | k;
            bus.resp_err   = 1'b1;
            @(negedge clk);
            check_eq("req_valid", bus.req_valid, 1);
            check_eq("req_addr", bus.req_addr, {addr[31:2], 2'b00});
            check_eq("req_wr", bus.req_wr, wen);
            check_eq("req_wstrb", bus.req_wstrb, model_strb(wen, size, addr));
            check_eq("req_wdata", bus.req_wdata, wdata);
            check_eq("req_wait", dmem_wait, 1);
            check_eq("req_badmem", dmem_badmem_e, 0);
        end
        for (int j = 0; j <= rsp_dly; j++) begin
            tick();
            bus.req_ready  = 1'b0;
            bus.resp_valid = (j == rsp_dly);
            bus.resp_rdata = (j == rsp_dly) ? rdata : (32'h5A5A_0000 | j);
            bus.resp_err   = (j == rsp_dly) ? err : 1'b1;
            if (j == rsp_dly) apply_next();
            @(negedge clk);
            check_eq("resp_req_valid", bus.req_valid, 0);
            check_eq("resp_wait", dmem_wait, (j != rsp_dly));
            if (j == rsp_dly) begin
                check_eq("sb_nonempty", exp_q.size() > 0, 1);
                exp = exp_q.pop_front();
                check_eq("resp_badmem", dmem_badmem_e, exp[32]);
                if (!wen) check_eq("resp_rdata", dmem_rdata, exp[31:0]);
            end else begin
                check_eq("resp_idle_badmem", dmem_badmem_e, 0);
                check_eq("resp_idle_rdata", dmem_rdata, 0);
            end
        end
        nxt_en = 1'b0;
    endtask

    task automatic access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rd_dly, input int rsp_dly,
                          input logic [31:0] rdata, input logic err);
        tick();
        clear_inputs();
        addr_phase(wen, size, addr);
        @(negedge clk);
        check_eq("addr_phase_wait", dmem_wait, 0);
        data_phase(wen, size, addr, wdata, rd_dly, rsp_dly, rdata, err, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, dbg_state, ST_IDLE);
        check_eq({tag, "_req_valid"}, bus.req_valid, 0);
        check_eq({tag, "_wait"}, dmem_wait, 0);
        check_eq({tag, "_badmem"}, dmem_badmem_e, 0);
        check_eq({tag, "_req_wr"}, bus.req_wr, 0);
        check_eq({tag, "_wstrb"}, bus.req_wstrb, 0);
        check_eq({tag, "_req_addr"}, bus.req_addr, 0);
        check_eq({tag, "_rdata"}, dmem_rdata, 0);
    endtask

    initial begin
        logic        c_wen, n_wen, chain;
        logic [2:0]  c_size, n_size;
        logic [31:0] c_addr, n_addr;

        reset_n            = 1'b0;
        dmem_wen           = 1'b0;
        dmem_size          = 3'd0;
        dmem_addr          = 32'h0;
        dmem_wdata_delayed = 32'h0;
        bus.resp_rdata     = 32'h0;
        nxt_en             = 1'b0;
        nxt_wen            = 1'b0;
        nxt_size           = 3'd0;
        nxt_addr           = 32'h0;
        clear_inputs();
        repeat (2) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        reset_n = 1'b1;

        // aligned store word, minimum latency
        access(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        // store byte with ready held low for 3 cycles
        access(1'b1, 3'd0, 32'h0000_0203, 32'h1111_1111, 3, 1, 32'h0, 1'b0);
        // load half
        access(1'b0, 3'd1, 32'h0000_0042, 32'h0, 0, 2, 32'h1234_ABCD, 1'b0);
        // misaligned word and illegal size code
        access(1'b0, 3'd2, 32'h0000_0101, 32'h0, 0, 0, 32'h0, 1'b0);
        access(1'b1, 3'd3, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 1'b0);
        tick();
        clear_inputs();
        @(negedge clk);
        check_eq("bad_after_req_valid", bus.req_valid, 0);

        // response offered in the request handshake cycle must not complete it
        tick();
        clear_inputs();
        addr_phase(1'b0, 3'd2, 32'h0000_0800);
        @(negedge clk);
        data_phase(1'b0, 3'd2, 32'h0000_0800, 32'h0, 1, 1, 32'hCAFE_F00D, 1'b0, 1'b1);

        // back-to-back: store with bus error, load captured in its completion cycle
        tick();
        clear_inputs();
        addr_phase(1'b1, 3'd2, 32'h0000_0500);
        @(negedge clk);
        nxt_en = 1'b1; nxt_wen = 1'b0; nxt_size = 3'd2; nxt_addr = 32'h0000_0600;
        data_phase(1'b1, 3'd2, 32'h0000_0500, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b1, 1'b0);
        data_phase(1'b0, 3'd2, 32'h0000_0600, 32'h0, 0, 0, 32'h7654_3210, 1'b0, 1'b0);

        // reset while in RESP, then a stray response
        tick();
        clear_inputs();
        addr_phase(1'b1, 3'd2, 32'h0000_0300);
        tick();
        dmem_en = 1'b0;
        bus.req_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_pre_wstrb", bus.req_wstrb, 4'hF);
        tick();
        bus.req_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_state", dbg_state, ST_RESP);
        check_eq("rst_pre_wait", dmem_wait, 1);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'hFFFF_FFFF;
        bus.resp_err   = 1'b1;
        @(negedge clk);
        check_eq("stray_wait", dmem_wait, 0);
        check_eq("stray_badmem", dmem_badmem_e, 0);
        check_eq("stray_rdata", dmem_rdata, 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check_eq("stray_state", dbg_state, ST_IDLE);

        // randomized accesses, optionally chained back-to-back
        c_wen  = 1'($urandom_range(0, 1));
        c_size = 3'($urandom_range(0, 3));
        c_addr = $urandom;
        tick();
        clear_inputs();
        addr_phase(c_wen, c_size, c_addr);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            n_wen  = 1'($urandom_range(0, 1));
            n_size = 3'($urandom_range(0, 3));
            n_addr = $urandom;
            chain  = 1'($urandom_range(0, 1));
            nxt_en = chain; nxt_wen = n_wen; nxt_size = n_size; nxt_addr = n_addr;
            data_phase(c_wen, c_size, c_addr, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if (!chain) begin
                tick();
                clear_inputs();
                addr_phase(n_wen, n_size, n_addr);
                @(negedge clk);
                check_eq("rand_addr_wait", dmem_wait, 0);
            end
            c_wen = n_wen; c_size = n_size; c_addr = n_addr;
        end
        data_phase(c_wen, c_size, c_addr, $urandom, 1, 1, $urandom, 1'b0, 1'b0);

        tick();
        clear_inputs();
        @(negedge clk);
        check_eq("final_state", dbg_state, ST_IDLE);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
